ycbcr_share_arb: RTL
====================

YCBCR_SHARE_ARB -- requirements
Module: ycbcr_share_arb

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with parameters as follows.
- LAT, 4: fixed latency of the shared converter, from conv_data_en input to converter data_en output.
- BURST, 8: maximum consecutive transfers granted to one source while the other is waiting.

REQ-002 The block SHALL have the following ports.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s0_valid / s1_valid  in  1  source pixel valid.
- s0_ready / s1_ready  out  1  source may transfer.
- s0_rgb / s1_rgb  in  24  pixel, packed {R[23:16], G[15:8], B[7:0]}.
- s0_sof / s1_sof  in  1  start-of-frame marker travelling with the pixel.
- conv_r / conv_g / conv_b  out  8  pixel driven to the shared converter.
- conv_data_en  out  1  converter input enable.
- conv_y / conv_cb / conv_cr  in  8  converter result.
- conv_data_en_o  in  1  converter result enable.
- m0_valid / m1_valid  out  1  one-cycle result strobe per source; there is no backpressure.
- m0_ycc / m1_ycc  out  24  result, packed {Y, Cb, Cr}.
- m0_sof / m1_sof  out  1  sof returned with the result.
- flush  in  1  request to stop issuing and drain.
- flush_done  out  1  flush is high and nothing is in flight.
- err_sync  out  1  sticky tag/converter enable mismatch flag.

Function
REQ-003 The block SHALL implement a state machine with states IDLE, GRANT0 and GRANT1, held in registers.
REQ-004 sK_ready SHALL equal (state==GRANTK) AND NOT flush, decoded combinationally from the state register.
REQ-005 A transfer on source K SHALL occur on a clock edge where sK_valid and sK_ready are both high.
REQ-006 From IDLE with flush low, the next state SHALL be the requesting source; if both request, the source not granted last SHALL win.
REQ-007 While in GRANTK with flush low, the next state SHALL be decided as follows.
- Stay in GRANTK while sK_valid is high and the burst count is below BURST.
- Switch to the other source if it is valid and either sK_valid is low or the burst count equals BURST.
- Go to IDLE if neither source is valid.
REQ-008 If the burst count equals BURST and the other source is idle, the state SHALL stay in GRANTK and the burst count SHALL restart at 0.
REQ-009 The burst count SHALL increment on each transfer and SHALL clear on any state change.
REQ-010 Flush high SHALL force the next state to IDLE from any state, and no transfer SHALL occur while flush is high.
REQ-011 On a transfer, conv_r/g/b SHALL be registered from the transferred pixel and conv_data_en SHALL be 1 in the following cycle; otherwise conv_data_en SHALL be 0 and conv_r/g/b SHALL hold their values.
REQ-012 A tag pipeline of LAT stages, each holding {valid, src, sof}, SHALL be launched alongside conv_data_en and SHALL shift every cycle.
REQ-013 When the tag pipeline's last stage is valid, conv_y/cb/cr SHALL be registered into m<src>_ycc with m<src>_sof, and m<src>_valid SHALL be 1 for exactly one cycle.
REQ-014 A transfer at edge T SHALL produce the matching mK_valid in cycle T+LAT+2.
REQ-015 Only one of m0_valid and m1_valid SHALL be high in any cycle.
REQ-016 mK_ycc SHALL hold its value when mK_valid is 0.
REQ-017 The results for each source SHALL be returned in the order that source transferred them.
REQ-018 err_sync SHALL be set when the tag pipeline's last-stage valid differs from conv_data_en_o, and SHALL clear only on reset.
REQ-019 flush_done SHALL equal flush AND (conv_data_en==0) AND (all tag stages invalid).
REQ-020 Deasserting flush SHALL resume normal arbitration from IDLE on the next edge.
REQ-021 The source granted last SHALL be remembered across IDLE, so that round-robin fairness persists.

Reset
REQ-022 While rst is high, the following outputs SHALL be 0: conv_data_en, conv_r/g/b, all mK outputs, sK_ready, flush_done and err_sync.
REQ-023 While rst is high, state SHALL be IDLE, burst count 0 and all tag stages invalid.
REQ-024 While rst is high, the source-granted-last record SHALL be 1, so that source 0 wins the first tie.
REQ-025 Pixels in flight at reset assertion SHALL be discarded, and no mK_valid SHALL appear for them after reset releases.

Verification
REQ-026 Single pixel test: s0 sends {R=255, G=0, B=0} with sof=1 at edge T, and the converter model (LAT=4) returns {82, 90, 240} -> m0_valid only at T+6, m0_ycc=0x525AF0, m0_sof=1, m1_valid never high.
REQ-027 Contention test: both sources are continuously valid with BURST=8 -> the grant sequence is 8 transfers from s0, then 8 from s1, repeating; every result is routed to its own source in order, and err_sync stays 0.
REQ-028 Idle-other test: only s1 is valid for 20 pixels -> s1 is granted every cycle after the first grant cycle, with no gaps at the burst boundary and no grant to s0.
REQ-029 Flush test: flush is raised while 3 pixels are in flight -> sK_ready is 0 immediately, flush_done rises once the third result strobe has been presented, and arbitration resumes from IDLE after flush drops.
REQ-030 Reset test: rst is asserted for 1 cycle with 2 pixels in flight -> all outputs are 0 during reset, no mK_valid follows, and after release s0 wins a tie.
REQ-031 Mismatch test: the converter model is given 5 cycles of latency instead of LAT=4 -> err_sync becomes 1 and stays 1 until the next reset.

Source files
------------

// File: rtl/ycbcr_share_arb.sv
// Two-source round-robin arbiter in front of one fixed-latency RGB->YCbCr converter.
// A tag pipeline follows each pixel through the converter and routes the result back.
module ycbcr_share_arb #(
   parameter int LAT   = 4,
   parameter int BURST = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s0_valid,
   output logic        s0_ready,
   input  logic [23:0] s0_rgb,
   input  logic        s0_sof,
   input  logic        s1_valid,
   output logic        s1_ready,
   input  logic [23:0] s1_rgb,
   input  logic        s1_sof,
   output logic [7:0]  conv_r,
   output logic [7:0]  conv_g,
   output logic [7:0]  conv_b,
   output logic        conv_data_en,
   input  logic [7:0]  conv_y,
   input  logic [7:0]  conv_cb,
   input  logic [7:0]  conv_cr,
   input  logic        conv_data_en_o,
   output logic        m0_valid,
   output logic [23:0] m0_ycc,
   output logic        m0_sof,
   output logic        m1_valid,
   output logic [23:0] m1_ycc,
   output logic        m1_sof,
   input  logic        flush,
   output logic        flush_done,
   output logic        err_sync
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   localparam int CNT_W = $clog2(BURST + 1);
   localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic             last, last_nxt;
   logic             xfer0, xfer1, xfer;
   logic             conv_src, conv_sof;
   logic [LAT-1:0]   tag_vld, tag_src, tag_sof;

   assign s0_ready = (state == GRANT0) && !flush;
   assign s1_ready = (state == GRANT1) && !flush;
   assign xfer0    = s0_valid && s0_ready;
   assign xfer1    = s1_valid && s1_ready;
   assign xfer     = xfer0 || xfer1;
   assign cnt_inc  = cnt + CNT_W'(xfer);

   // burst decisions use the count including this cycle's transfer
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_inc;
      last_nxt  = last;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!flush) begin
               if (s0_valid && s1_valid) state_nxt = last ? GRANT0 : GRANT1;
               else if (s0_valid)        state_nxt = GRANT0;
               else if (s1_valid)        state_nxt = GRANT1;
            end
         end
         GRANT0: begin
            if (flush)                              state_nxt = IDLE;
            else if (s0_valid && cnt_inc < BURST_C) state_nxt = GRANT0;
            else if (s1_valid)                      state_nxt = GRANT1;
            else if (s0_valid)                      cnt_nxt   = '0;
            else                                    state_nxt = IDLE;
         end
         GRANT1: begin
            if (flush)                              state_nxt = IDLE;
            else if (s1_valid && cnt_inc < BURST_C) state_nxt = GRANT1;
            else if (s0_valid)                      state_nxt = GRANT0;
            else if (s1_valid)                      cnt_nxt   = '0;
            else                                    state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
      if (state_nxt != state) cnt_nxt = '0;
      if (state_nxt == GRANT0 && state != GRANT0) last_nxt = 1'b0;
      if (state_nxt == GRANT1 && state != GRANT1) last_nxt = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         last  <= last_nxt;
      end
   end

   // converter launch stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conv_data_en <= 1'b0;
         conv_r       <= '0;
         conv_g       <= '0;
         conv_b       <= '0;
         conv_src     <= 1'b0;
         conv_sof     <= 1'b0;
      end else begin
         conv_data_en <= xfer;
         if (xfer) begin
            {conv_r, conv_g, conv_b} <= xfer1 ? s1_rgb : s0_rgb;
            conv_src                 <= xfer1;
            conv_sof                 <= xfer1 ? s1_sof : s0_sof;
         end
      end
   end

   // tag pipeline, aligned with the converter's internal latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld <= '0;
         tag_src <= '0;
         tag_sof <= '0;
      end else begin
         tag_vld[0] <= conv_data_en;
         tag_src[0] <= conv_src;
         tag_sof[0] <= conv_sof;
         for (int i = 1; i < LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_src[i] <= tag_src[i-1];
            tag_sof[i] <= tag_sof[i-1];
         end
      end
   end

   // result demux stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m0_valid <= 1'b0;
         m0_ycc   <= '0;
         m0_sof   <= 1'b0;
         m1_valid <= 1'b0;
         m1_ycc   <= '0;
         m1_sof   <= 1'b0;
         err_sync <= 1'b0;
      end else begin
         m0_valid <= tag_vld[LAT-1] && !tag_src[LAT-1];
         m1_valid <= tag_vld[LAT-1] &&  tag_src[LAT-1];
         if (tag_vld[LAT-1] && !tag_src[LAT-1]) begin
            m0_ycc <= {conv_y, conv_cb, conv_cr};
            m0_sof <= tag_sof[LAT-1];
         end
         if (tag_vld[LAT-1] && tag_src[LAT-1]) begin
            m1_ycc <= {conv_y, conv_cb, conv_cr};
            m1_sof <= tag_sof[LAT-1];
         end
         if (tag_vld[LAT-1] != conv_data_en_o) err_sync <= 1'b1;
      end
   end

   assign flush_done = flush && !rst && !conv_data_en && (tag_vld == '0);

endmodule
